ram_tdp_be: RTL and testbench

Single-clock true dual-port RAM with per-byte write strobes, selectable same-port read-during-write mode, an optional output pipeline register and a hardware clear engine. It zeroes the whole array after reset. It is the general-purpose buffer for packet and descriptor storage in single-clock-domain datapaths.

---
 rtl/ram_pkg.sv | 6 +
 rtl/ram_tdp_be_port.sv | 70 +++++++
 rtl/ram_tdp_be.sv | 78 +++++++
 tb/tb_ram_tdp_be.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared encodings for the byte-strobed true dual-port RAM
package ram_pkg;
  localparam int RAM_WRITE_FIRST = 0;
  localparam int RAM_READ_FIRST = 1;
  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} clr_state_e;
endpackage

// File: rtl/ram_tdp_be_port.sv
// ram_tdp_be_port: per-port accept gating, byte merge, read-mode mux and output stage
module ram_tdp_be_port
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int READ_MODE = RAM_WRITE_FIRST,
  parameter int PIPELINE_OUTPUT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ready,
  input  logic                  en,
  input  logic [STRB_WIDTH-1:0] we,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [STRB_WIDTH-1:0] wr_strb,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid
);
  logic                  acc;
  logic [DATA_WIDTH-1:0] merged, rd_word;
  logic [DATA_WIDTH-1:0] dout1_d, dout1_q;
  logic                  v1_d, v1_q;
  assign acc = en & ready;
  assign wr_strb = acc ? we : '0;
  // post-write word as this port alone would leave it
  always_comb begin
    merged = rdata;
    for (int k = 0; k < STRB_WIDTH; k++)
      merged[8*k+:8] = wr_strb[k] ? din[8*k+:8] : rdata[8*k+:8];
    rd_word = (READ_MODE == RAM_READ_FIRST) ? rdata : merged;
    dout1_d = acc ? rd_word : dout1_q;
    v1_d = acc;
  end
  // first output stage: captures the read word of an accepted access
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      dout1_q <= dout1_d;
      v1_q <= v1_d;
    end
  end
  if (PIPELINE_OUTPUT != 0) begin : g_pipe
    logic [DATA_WIDTH-1:0] dout2_d, dout2_q;
    logic                  v2_d, v2_q;
    // second stage holds its word until the next valid arrives
    always_comb begin
      dout2_d = v1_q ? dout1_q : dout2_q;
      v2_d = v1_q;
    end
    // optional output register, reset cancels in-flight pulses
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dout2_q <= '0;
        v2_q <= 1'b0;
      end else begin
        dout2_q <= dout2_d;
        v2_q <= v2_d;
      end
    end
    assign dout = dout2_q;
    assign dout_valid = v2_q;
  end else begin : g_direct
    assign dout = dout1_q;
    assign dout_valid = v1_q;
  end
endmodule

// File: rtl/ram_tdp_be.sv
// ram_tdp_be: true dual-port RAM with byte strobes and post-reset clear engine
module ram_tdp_be
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int READ_MODE = RAM_WRITE_FIRST,
  parameter int PIPELINE_OUTPUT = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_en,
  input  logic [STRB_WIDTH-1:0] a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_dout_valid,
  input  logic                  b_en,
  input  logic [STRB_WIDTH-1:0] b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  b_dout_valid,
  output logic                  init_busy
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  clr_state_e            state_d, state_q;
  logic [ADDR_WIDTH-1:0] cnt_d, cnt_q;
  logic                  ready;
  logic [STRB_WIDTH-1:0] a_wr, b_wr;
  logic [DATA_WIDTH-1:0] a_rdata, b_rdata;
  assign ready = state_q == ST_READY;
  assign init_busy = !ready;
  assign a_rdata = mem[a_addr];
  assign b_rdata = mem[b_addr];
  // clear sequencing: one word per cycle, then ready until next reset
  always_comb begin
    state_d = state_q == ST_RESET ? (CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_READY) :
              (state_q == ST_CLEAR && cnt_q == '1) ? ST_READY : state_q;
    cnt_d = state_q == ST_CLEAR ? cnt_q + 1'b1 : '0;
  end
  // clear FSM state and address counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // array write: B first so A overrides bytes both ports strobe
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) mem[cnt_q] <= '0;
    else
      for (int k = 0; k < STRB_WIDTH; k++) begin
        if (b_wr[k]) mem[b_addr][8*k+:8] <= b_din[8*k+:8];
        if (a_wr[k]) mem[a_addr][8*k+:8] <= a_din[8*k+:8];
      end
  end
  ram_tdp_be_port #(
    .DATA_WIDTH(DATA_WIDTH), .STRB_WIDTH(STRB_WIDTH),
    .READ_MODE(READ_MODE), .PIPELINE_OUTPUT(PIPELINE_OUTPUT)
  ) u_port_a (
    .clk(clk), .rst_n(rst_n), .ready(ready), .en(a_en), .we(a_we), .din(a_din),
    .rdata(a_rdata), .wr_strb(a_wr), .dout(a_dout), .dout_valid(a_dout_valid)
  );
  ram_tdp_be_port #(
    .DATA_WIDTH(DATA_WIDTH), .STRB_WIDTH(STRB_WIDTH),
    .READ_MODE(READ_MODE), .PIPELINE_OUTPUT(PIPELINE_OUTPUT)
  ) u_port_b (
    .clk(clk), .rst_n(rst_n), .ready(ready), .en(b_en), .we(b_we), .din(b_din),
    .rdata(b_rdata), .wr_strb(b_wr), .dout(b_dout), .dout_valid(b_dout_valid)
  );
endmodule

// File: tb/tb_ram_tdp_be.sv
// tb_ram_tdp_be: scoreboard bench driving a write-first/direct and a read-first/pipelined instance
module tb_ram_tdp_be;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_en, b_en;
  logic [3:0]  a_we, b_we, a_addr, b_addr;
  logic [31:0] a_din, b_din;
  logic [31:0] a_dout0, b_dout0, a_dout1, b_dout1;
  logic        a_v0, b_v0, a_v1, b_v1, busy0, busy1;
  typedef struct {logic [31:0] d; int c;} exp_t;
  exp_t        q[4][$];
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;
  logic [31:0] ref_mem [16];
  bit          model_ready = 0;
  int          n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_tdp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_MODE(0), .PIPELINE_OUTPUT(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout0), .a_dout_valid(a_v0),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout0), .b_dout_valid(b_v0),
    .init_busy(busy0)
  );
  ram_tdp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_MODE(1), .PIPELINE_OUTPUT(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout1), .a_dout_valid(a_v1),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout1), .b_dout_valid(b_v1),
    .init_busy(busy1)
  );

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic mon(int i, string nm, logic v, logic [31:0] d);
    exp_t e;
    if (!v) return;
    if (q[i].size() == 0) begin
      checks++;
      $display("FAIL %s unexpected valid: got %h expected no output", nm, d);
    end else begin
      e = q[i].pop_front();
      chk({nm, " data"}, d, e.d);
      chk({nm, " cycle"}, cyc, e.c);
    end
  endtask

  always @(negedge clk) begin
    mon(0, "u0 A", a_v0, a_dout0);
    mon(1, "u0 B", b_v0, b_dout0);
    mon(2, "u1 A", a_v1, a_dout1);
    mon(3, "u1 B", b_v1, b_dout1);
  end

  task automatic step(logic ae, logic [3:0] awe, logic [3:0] aad, logic [31:0] adi,
                      logic be, logic [3:0] bwe, logic [3:0] bad, logic [31:0] bdi);
    logic [31:0] ao, bo, am, bm;
    @(posedge clk);
    #1;
    a_en = ae; a_we = awe; a_addr = aad; a_din = adi;
    b_en = be; b_we = bwe; b_addr = bad; b_din = bdi;
    if (model_ready) begin
      ao = ref_mem[aad];
      bo = ref_mem[bad];
      for (int k = 0; k < 4; k++) begin
        am[8*k+:8] = awe[k] ? adi[8*k+:8] : ao[8*k+:8];
        bm[8*k+:8] = bwe[k] ? bdi[8*k+:8] : bo[8*k+:8];
      end
      if (ae) begin
        q[0].push_back('{am, cyc + 1});
        q[2].push_back('{ao, cyc + 2});
      end
      if (be) begin
        q[1].push_back('{bm, cyc + 1});
        q[3].push_back('{bo, cyc + 2});
      end
      for (int k = 0; k < 4; k++) begin
        if (be && bwe[k]) ref_mem[bad][8*k+:8] = bdi[8*k+:8];
        if (ae && awe[k]) ref_mem[aad][8*k+:8] = adi[8*k+:8];
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_clear(bit poke, output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy0) break;
      cnt++;
      a_en = poke; a_we = 4'hF; a_addr = 4'd2; a_din = 32'hFFFF_FFFF;
    end
    a_en = 0; a_we = 0; a_addr = 0; a_din = 0;
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 16; i++) step(1, 0, i[3:0], 0, 1, 0, 4'(15 - i), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0;
    a_en = 0; a_we = 0; a_addr = 0; a_din = 0;
    b_en = 0; b_we = 0; b_addr = 0; b_din = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset a_dout u0", a_dout0, 0);
    chk("reset b_dout u1", b_dout1, 0);
    chk("reset a_valid u0", {31'd0, a_v0}, 0);
    chk("reset b_valid u1", {31'd0, b_v1}, 0);
    chk("reset busy u0", {31'd0, busy0}, 1);
    chk("reset busy u1", {31'd0, busy1}, 1);
    rst_n = 1;
    @(posedge clk);
    run_clear(0, n);
    chk("clear length", n, 16);
    chk("busy u1 after clear", {31'd0, busy1}, 0);
    model_ready = 1;
    read_all_zero();
    step(1, 4'hF, 3, 32'hDEAD_BEEF, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4'b0010, 3, 32'h0000_AA00);
    step(1, 0, 3, 0, 0, 0, 0, 0);
    step(1, 4'hF, 5, 32'h2222_2222, 0, 0, 0, 0);
    step(1, 4'hF, 5, 32'h1111_1111, 0, 0, 0, 0);
    step(1, 4'hF, 7, 32'hAAAA_AAAA, 1, 4'hF, 7, 32'h5555_5555);
    step(0, 0, 0, 0, 1, 0, 7, 0);
    step(1, 4'b0011, 8, 32'h1122_3344, 1, 4'b0110, 8, 32'hAABB_CCDD);
    step(1, 0, 8, 0, 0, 0, 0, 0);
    step(1, 4'hF, 9, 32'h1234_5678, 1, 0, 9, 0);
    step(1, 0, 9, 0, 1, 0, 9, 0);
    for (int i = 0; i < 16; i++) step(1, 4'hF, i[3:0], i, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 0, i[3:0], 0, 1, 0, i[3:0], 0);
    repeat (3) idle();
    step(1, 0, 3, 0, 1, 0, 3, 0);
    model_ready = 0;
    @(posedge clk);
    #1;
    rst_n = 0;
    a_en = 0; b_en = 0;
    q[2].delete();
    q[3].delete();
    repeat (2) @(posedge clk);
    #1;
    chk("reset cancels u1 A valid", {31'd0, a_v1}, 0);
    chk("reset clears u1 A dout", a_dout1, 0);
    chk("reset clears u0 B dout", b_dout0, 0);
    rst_n = 1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk);
    #1;
    chk("busy during mid-clear reset", {31'd0, busy0}, 1);
    rst_n = 1;
    @(posedge clk);
    run_clear(1, n);
    chk("restarted clear length", n, 16);
    for (int i = 0; i < 16; i++) ref_mem[i] = 0;
    model_ready = 1;
    read_all_zero();
    repeat (4) idle();
    for (int i = 0; i < 4; i++) chk("queue drained", q[i].size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
